// File: rtl/tt_pin_host.sv
// Host-side pin driver for a TinyTapeout user project: executes byte commands
// that set project inputs, pulse project reset, wait, or sample project outputs.
module tt_pin_host #(
    parameter int RST_CYCLES = 10,
    parameter int SETTLE     = 2,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [7:0]  rsp_oe,
    output logic [7:0]  proj_ui_in,
    output logic [7:0]  proj_uio_in,
    output logic        proj_ena,
    output logic        proj_rst_n,
    input  logic [7:0]  proj_uo_out,
    input  logic [7:0]  proj_uio_out,
    input  logic [7:0]  proj_uio_oe
);

    typedef enum logic [1:0] {S_IDLE, S_RSTP, S_SETTLE, S_WAIT} state_t;

    localparam logic [2:0] OP_SET_UI  = 3'd1;
    localparam logic [2:0] OP_SET_UIO = 3'd2;
    localparam logic [2:0] OP_SET_ENA = 3'd3;
    localparam logic [2:0] OP_PULSE   = 3'd4;
    localparam logic [2:0] OP_SAMPLE  = 3'd5;
    localparam logic [2:0] OP_WAIT    = 3'd6;

    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);
    // Capture happens when the settle count reaches zero, so loading SETTLE
    // lands the capture SETTLE+1 edges after accept (next edge when SETTLE=0).
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       ui_q;
    logic [7:0]       uio_q;
    logic             ena_q;
    logic             prst_n_q;
    logic             rsp_valid_q;
    logic [15:0]      rsp_data_q;
    logic [7:0]       rsp_oe_q;
    logic [7:0]       uio_smp_d;
    logic             accept_d;

    assign cmd_ready   = (state_q == S_IDLE) && !rsp_valid_q;
    assign accept_d    = cmd_valid && cmd_ready;
    // Bidirectional pins read back what the project drives, else what we drive.
    assign uio_smp_d   = (proj_uio_out & proj_uio_oe) | (uio_q & ~proj_uio_oe);

    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_oe      = rsp_oe_q;
    assign proj_ui_in  = ui_q;
    assign proj_uio_in = uio_q;
    assign proj_ena    = ena_q;
    assign proj_rst_n  = prst_n_q;

    // Command FSM, pin registers and response buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= CNT_ZERO;
            ui_q        <= 8'h00;
            uio_q       <= 8'h00;
            ena_q       <= 1'b0;
            prst_n_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'h0000;
            rsp_oe_q    <= 8'h00;
        end else begin
            if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        case (cmd_op)
                            OP_SET_UI:  ui_q  <= cmd_data;
                            OP_SET_UIO: uio_q <= cmd_data;
                            OP_SET_ENA: ena_q <= cmd_data[0];
                            OP_PULSE: begin
                                prst_n_q <= 1'b0;
                                cnt_q    <= RST_LOAD;
                                state_q  <= S_RSTP;
                            end
                            OP_SAMPLE: begin
                                cnt_q   <= SETTLE_LOAD;
                                state_q <= S_SETTLE;
                            end
                            OP_WAIT: begin
                                if (cmd_data != 8'd0) begin
                                    cnt_q   <= CNT_W'(cmd_data - 8'd1);
                                    state_q <= S_WAIT;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_RSTP: begin
                    if (cnt_q == CNT_ZERO) begin
                        prst_n_q <= 1'b1;
                        state_q  <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == CNT_ZERO) begin
                        rsp_data_q  <= {proj_uo_out, uio_smp_d};
                        rsp_oe_q    <= proj_uio_oe;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == CNT_ZERO) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_pin_host.sv
// Directed self-checking bench for tt_pin_host with a project stub (uo_out = ~ui_in).
module tb_tt_pin_host;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [7:0]  rsp_oe;
    logic [7:0]  proj_ui_in;
    logic [7:0]  proj_uio_in;
    logic        proj_ena;
    logic        proj_rst_n;
    logic [7:0]  proj_uo_out;
    logic [7:0]  proj_uio_out;
    logic [7:0]  proj_uio_oe;

    int total = 0;
    int bad   = 0;
    int n;
    int waited;

    tt_pin_host #(.RST_CYCLES(10), .SETTLE(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_oe(rsp_oe),
        .proj_ui_in(proj_ui_in), .proj_uio_in(proj_uio_in), .proj_ena(proj_ena),
        .proj_rst_n(proj_rst_n), .proj_uo_out(proj_uo_out), .proj_uio_out(proj_uio_out),
        .proj_uio_oe(proj_uio_oe)
    );

    always #5 clk = ~clk;

    assign proj_uo_out = ~proj_ui_in;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and return just after its accept edge.
    task automatic send(input logic [2:0] op, input logic [7:0] data, output int w);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        w = 0;
        while (!cmd_ready && w < 50) begin
            tick();
            w++;
        end
        if (!cmd_ready) chk_eq("send_timeout", 32'd0, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int k;
        k = 0;
        while (!rsp_valid && k < 50) begin
            tick();
            k++;
        end
        chk_eq("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk_eq("rsp_cleared", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'h00;
        rsp_ready = 1'b0; proj_uio_out = 8'h00; proj_uio_oe = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_eq("rst_ui",    {24'd0, proj_ui_in},  32'h0);
        chk_eq("rst_uio",   {24'd0, proj_uio_in}, 32'h0);
        chk_eq("rst_ena",   {31'd0, proj_ena},    32'h0);
        chk_eq("rst_rstn",  {31'd0, proj_rst_n},  32'h0);
        chk_eq("rst_rspv",  {31'd0, rsp_valid},   32'h0);
        chk_eq("rst_rspd",  {16'd0, rsp_data},    32'h0);
        chk_eq("rst_ready", {31'd0, cmd_ready},   32'h1);

        // Project reset pulse: low exactly 10 cycles, ready returns with rst_n.
        send(3'd4, 8'h00, waited);
        n = 0;
        while (proj_rst_n == 1'b0 && n < 50) begin
            chk_eq("pulse_ready_lo", {31'd0, cmd_ready}, 32'h0);
            n++;
            tick();
        end
        chk_eq("pulse_len",      n, 32'd10);
        chk_eq("pulse_ready_hi", {31'd0, cmd_ready}, 32'h1);
        send(3'd3, 8'h01, waited);
        chk_eq("ena_set", {31'd0, proj_ena}, 32'h1);

        // Sample latency and uo capture.
        send(3'd1, 8'hA5, waited);
        chk_eq("ui_set", {24'd0, proj_ui_in}, 32'hA5);
        send(3'd5, 8'h00, waited);
        for (int i = 0; i < 3; i++) begin
            chk_eq("smp_early", {31'd0, rsp_valid}, 32'h0);
            tick();
        end
        chk_eq("smp_valid", {31'd0, rsp_valid}, 32'h1);
        chk_eq("smp_data",  {16'd0, rsp_data},  32'h5A00);
        chk_eq("smp_oe",    {24'd0, rsp_oe},    32'h00);
        consume();

        // uio readback merges project-driven and host-driven bits.
        proj_uio_oe  = 8'hF0;
        proj_uio_out = 8'h90;
        send(3'd2, 8'h3C, waited);
        send(3'd5, 8'h00, waited);
        wait_rsp();
        chk_eq("uio_data", {16'd0, rsp_data}, 32'h5A9C);
        chk_eq("uio_oe",   {24'd0, rsp_oe},   32'hF0);
        consume();

        // Backpressure: response held, next command stalled.
        send(3'd5, 8'h00, waited);
        wait_rsp();
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = 8'h77;
        for (int i = 0; i < 5; i++) begin
            chk_eq("bp_ready", {31'd0, cmd_ready},  32'h0);
            chk_eq("bp_data",  {16'd0, rsp_data},   32'h5A9C);
            chk_eq("bp_ui",    {24'd0, proj_ui_in}, 32'hA5);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk_eq("bp_cleared", {31'd0, rsp_valid},  32'h0);
        chk_eq("bp_ready1",  {31'd0, cmd_ready},  32'h1);
        chk_eq("bp_ui_hold", {24'd0, proj_ui_in}, 32'hA5);
        tick();
        cmd_valid = 1'b0;
        chk_eq("bp_ui_new", {24'd0, proj_ui_in}, 32'h77);

        // WAIT 4 keeps the block busy exactly 4 cycles.
        send(3'd6, 8'h04, waited);
        n = 0;
        while (!cmd_ready && n < 50) begin
            n++;
            tick();
        end
        chk_eq("wait_len", n, 32'd4);
        send(3'd1, 8'h11, waited);
        chk_eq("wait_stall", waited, 32'd0);
        chk_eq("wait_ui",    {24'd0, proj_ui_in}, 32'h11);

        // WAIT 0 and reserved opcode have no effect.
        send(3'd6, 8'h00, waited);
        chk_eq("wait0_ready", {31'd0, cmd_ready}, 32'h1);
        send(3'd7, 8'hFF, waited);
        chk_eq("op7_ui",  {24'd0, proj_ui_in},  32'h11);
        chk_eq("op7_uio", {24'd0, proj_uio_in}, 32'h3C);

        // Reset in the middle of a long WAIT.
        send(3'd6, 8'h0A, waited);
        tick();
        tick();
        chk_eq("mid_busy", {31'd0, cmd_ready}, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_eq("mid_ready", {31'd0, cmd_ready},   32'h1);
        chk_eq("mid_ui",    {24'd0, proj_ui_in},  32'h0);
        chk_eq("mid_uio",   {24'd0, proj_uio_in}, 32'h0);
        chk_eq("mid_ena",   {31'd0, proj_ena},    32'h0);
        chk_eq("mid_rstn",  {31'd0, proj_rst_n},  32'h0);
        chk_eq("mid_rspv",  {31'd0, rsp_valid},   32'h0);

        // Reset drops a pending response.
        send(3'd5, 8'h00, waited);
        wait_rsp();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_eq("drop_rspv", {31'd0, rsp_valid}, 32'h0);
        chk_eq("drop_rspd", {16'd0, rsp_data},  32'h0);
        chk_eq("drop_oe",   {24'd0, rsp_oe},    32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tt_pin_host.md
Name: tt_pin_host

Overview:
- Host-side driver for a TinyTapeout user project: the counterpart that owns the project's pins.
- Accepts a byte-command stream over a valid/ready interface.
- Drives the project's ui_in, uio_in, ena and rst_n, and samples uo_out / uio_out / uio_oe after a programmable settle time.
- Returns samples over a valid/ready response channel. Used in on-chip self-test and FPGA bring-up harnesses in place of the cocotb driver.

Parameters:
- RST_CYCLES, 10, cycles proj_rst_n is held low by PULSE_RST (>=1).
- SETTLE, 2, idle cycles between SAMPLE accept and pin capture (>=0).
- CNT_W, 8, wait/reset counter width; must hold max(RST_CYCLES, 255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  3  opcode
- cmd_data  in  8  operand
- rsp_valid  out  1  sample available
- rsp_ready  in  1  consumer takes sample
- rsp_data  out  16  {uo_sample[7:0], uio_sample[7:0]}
- rsp_oe  out  8  proj_uio_oe captured with the sample
- proj_ui_in  out  8  to project ui_in
- proj_uio_in  out  8  to project uio_in
- proj_ena  out  1  to project ena
- proj_rst_n  out  1  to project rst_n (active-low)
- proj_uo_out  in  8  from project uo_out
- proj_uio_out  in  8  from project uio_out
- proj_uio_oe  in  8  from project uio_oe

Behaviour:
- Reset (rst=1 at a clk edge): proj_ui_in=0, proj_uio_in=0, proj_ena=0, proj_rst_n=0, rsp_valid=0, rsp_data=0, rsp_oe=0, counter=0, state=IDLE.
- After reset, proj_rst_n stays 0 until a PULSE_RST completes.
- rst mid-operation aborts any wait, reset pulse or pending response. A pending response is dropped.
- States: IDLE, RSTP, SETTLE, WAIT.
- cmd_ready = (state==IDLE) && !rsp_valid. Handshake occurs on an edge with cmd_valid && cmd_ready.
- Opcodes, all acted on at the accept edge:
  - 0 NOP: no effect.
  - 1 SET_UI: proj_ui_in <= cmd_data. Visible the cycle after accept.
  - 2 SET_UIO: proj_uio_in <= cmd_data.
  - 3 SET_ENA: proj_ena <= cmd_data[0].
  - 4 PULSE_RST: proj_rst_n <= 0, counter <= RST_CYCLES-1, go to RSTP.
    - RSTP decrements each cycle. At counter==0: proj_rst_n <= 1, go to IDLE.
    - proj_rst_n is low exactly RST_CYCLES cycles. cmd_ready rises in the same cycle proj_rst_n rises.
  - 5 SAMPLE: with SETTLE=0, capture at the next edge. Otherwise load counter with SETTLE-1, go to SETTLE, decrement to 0, then capture on the following edge.
    - Capture edge = accept edge + SETTLE + 1.
    - At capture: rsp_data[15:8] <= proj_uo_out; rsp_data[7:0] <= (proj_uio_out & proj_uio_oe) | (proj_uio_in & ~proj_uio_oe); rsp_oe <= proj_uio_oe; rsp_valid <= 1; state <= IDLE.
  - 6 WAIT: cmd_data==0 is a NOP. Otherwise counter <= cmd_data-1, go to WAIT, return to IDLE after exactly cmd_data cycles.
  - 7: reserved, treated as NOP.
- Response: rsp_valid holds, and rsp_data/rsp_oe stay stable, until an edge with rsp_ready=1. That edge clears rsp_valid.
  - cmd_ready is low while rsp_valid=1, so the response buffer never overflows.
  - rsp_ready is ignored when rsp_valid=0.
- Commands other than PULSE_RST/SAMPLE/WAIT complete in one cycle. Back-to-back accepts are possible every cycle.
- Pin outputs change only on command accept, RSTP completion, or reset. They are never combinational from cmd_*.
- Counter arithmetic is unsigned, CNT_W bits. No wrap occurs because loads are bounded by the parameter checks above.

Test Plan:
- Reset: hold rst 2 cycles, then release -> all proj_* outputs 0, proj_rst_n=0, rsp_valid=0, cmd_ready=1 the first cycle after release.
- PULSE_RST with RST_CYCLES=10 -> proj_rst_n low 10 consecutive cycles, then 1; cmd_ready=0 during the pulse and back to 1 in the same cycle rst_n rises. Then SET_ENA 1 -> proj_ena=1 one cycle later.
- SET_UI 0xA5, then SAMPLE, with the project stub returning uo_out=~ui_in -> rsp_valid exactly SETTLE+1=3 cycles after accept, rsp_data[15:8]=0x5A.
- SET_UIO 0x3C, project uio_oe=0xF0, uio_out=0x90, SAMPLE -> rsp_data[7:0]=0x9C, rsp_oe=0xF0.
- SAMPLE with rsp_ready held 0 for 5 cycles while cmd_valid=1 with SET_UI -> rsp_data stable and cmd_ready=0 throughout. SET_UI is accepted the cycle after rsp_ready=1 clears rsp_valid.
- WAIT 0x04 then SET_UI 0x11, and separately rst asserted mid-WAIT -> SET_UI accepted exactly 4 cycles after the WAIT accept. On mid-WAIT reset, state returns to IDLE and all outputs return to their reset values on the next edge.
